// File: rtl/kb_cursor_ctrl_if.sv
// Signal bundle between the PS/2 receiver / board updater and the cursor controller.
interface kb_cursor_ctrl_if;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        done_bu;
  logic [5:0]  cursor;
  logic        enter_pressed;
  logic        confirm_pressed;
  logic        esc_pressed;
  logic        busy;
  logic        timeout_err;
  logic [15:0] seg_code;

  modport master (
    output scan_code, scan_valid, done_bu,
    input  cursor, enter_pressed, confirm_pressed, esc_pressed, busy, timeout_err, seg_code
  );

  modport slave (
    input  scan_code, scan_valid, done_bu,
    output cursor, enter_pressed, confirm_pressed, esc_pressed, busy, timeout_err, seg_code
  );
endinterface

// File: rtl/kb_cursor_ctrl.sv
// PS/2 scan-code parser driving an 8x8 board cursor and a select/confirm/wait
// handshake with the board updater, including a bounded wait for done_bu.
module kb_cursor_ctrl #(
  parameter logic [2:0]  RESET_X    = 3'd0,
  parameter logic [2:0]  RESET_Y    = 3'd1,
  parameter logic [23:0] BU_TIMEOUT = 24'd1_000_000
) (
  input logic             clk50,
  input logic             RST,
  kb_cursor_ctrl_if.slave bus
);

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXT_BRK} pstate_t;
  typedef enum logic [1:0] {S_IDLE, S_SEL, S_WAIT} sstate_t;
  typedef enum logic [2:0] {K_NONE, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_ENTER, K_ESC} key_t;

  function automatic key_t decode_key(input logic ext, input logic [7:0] code);
    key_t k;
    k = K_NONE;
    if (ext) begin
      case (code)
        8'h75:   k = K_UP;
        8'h72:   k = K_DOWN;
        8'h6B:   k = K_LEFT;
        8'h74:   k = K_RIGHT;
        8'h5A:   k = K_ENTER;
        default: k = K_NONE;
      endcase
    end else begin
      case (code)
        8'h1D:   k = K_UP;
        8'h1B:   k = K_DOWN;
        8'h1C:   k = K_LEFT;
        8'h23:   k = K_RIGHT;
        8'h5A:   k = K_ENTER;
        8'h76:   k = K_ESC;
        default: k = K_NONE;
      endcase
    end
    return k;
  endfunction

  pstate_t     p_q, p_d;
  sstate_t     s_q, s_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic        enter_held_q, enter_held_d, esc_held_q, esc_held_d;
  logic [23:0] cnt_q, cnt_d;
  logic        enter_pressed_q, enter_pressed_d, confirm_q, confirm_d, esc_q, esc_d;
  logic        busy_q, busy_d, terr_q, terr_d;
  logic [15:0] seg_q, seg_d;

  logic        is_make_s, is_brk_s, ext_s, act_enter_s, act_esc_s;
  key_t        key_s;

  // Byte parser: prefix tracking and make/break event extraction
  always_comb begin
    p_d       = p_q;
    is_make_s = 1'b0;
    is_brk_s  = 1'b0;
    ext_s     = 1'b0;
    if (bus.scan_valid) begin
      case (p_q)
        P_IDLE: begin
          if (bus.scan_code == 8'hE0)      p_d = P_EXT;
          else if (bus.scan_code == 8'hF0) p_d = P_BRK;
          else                             is_make_s = 1'b1;
        end
        P_EXT: begin
          if (bus.scan_code == 8'hF0) begin
            p_d = P_EXT_BRK;
          end else begin
            is_make_s = 1'b1;
            ext_s     = 1'b1;
            p_d       = P_IDLE;
          end
        end
        P_BRK: begin
          is_brk_s = 1'b1;
          p_d      = P_IDLE;
        end
        P_EXT_BRK: begin
          is_brk_s = 1'b1;
          ext_s    = 1'b1;
          p_d      = P_IDLE;
        end
        default: p_d = P_IDLE;
      endcase
    end else begin
      p_d = p_q;
    end
    key_s = decode_key(ext_s, bus.scan_code);
  end

  // Held flags follow the physical key; only the first make of ENTER/ESC acts
  always_comb begin
    enter_held_d = enter_held_q;
    esc_held_d   = esc_held_q;
    if (key_s == K_ENTER) enter_held_d = is_make_s ? 1'b1 : (is_brk_s ? 1'b0 : enter_held_q);
    else                  enter_held_d = enter_held_q;
    if (key_s == K_ESC)   esc_held_d = is_make_s ? 1'b1 : (is_brk_s ? 1'b0 : esc_held_q);
    else                  esc_held_d = esc_held_q;
    act_enter_s = is_make_s && (key_s == K_ENTER) && !enter_held_q;
    act_esc_s   = is_make_s && (key_s == K_ESC) && !esc_held_q;
  end

  // Selection FSM, cursor movement, wait timeout and registered output values
  always_comb begin
    s_d       = s_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    confirm_d = 1'b0;
    esc_d     = 1'b0;
    terr_d    = 1'b0;
    seg_d     = is_make_s ? {7'b0, ext_s, bus.scan_code} : seg_q;
    if (is_make_s && (s_q != S_WAIT)) begin
      case (key_s)
        K_UP:    y_d = (y_q != 3'd7) ? y_q + 3'd1 : y_q;
        K_DOWN:  y_d = (y_q != 3'd0) ? y_q - 3'd1 : y_q;
        K_RIGHT: x_d = (x_q != 3'd7) ? x_q + 3'd1 : x_q;
        K_LEFT:  x_d = (x_q != 3'd0) ? x_q - 3'd1 : x_q;
        default: begin
          x_d = x_q;
          y_d = y_q;
        end
      endcase
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    case (s_q)
      S_IDLE: begin
        cnt_d = 24'd0;
        if (act_enter_s)    s_d = S_SEL;
        else if (act_esc_s) esc_d = 1'b1;
        else                s_d = S_IDLE;
      end
      S_SEL: begin
        cnt_d = 24'd0;
        if (act_enter_s) begin
          confirm_d = 1'b1;
          s_d       = S_WAIT;
        end else if (act_esc_s) begin
          esc_d = 1'b1;
          s_d   = S_IDLE;
        end else begin
          s_d = S_SEL;
        end
      end
      S_WAIT: begin
        // done_bu has priority over an expiry in the same cycle
        if (bus.done_bu) begin
          s_d = S_IDLE;
        end else if (cnt_q == BU_TIMEOUT - 24'd1) begin
          terr_d = 1'b1;
          s_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      default: s_d = S_IDLE;
    endcase
    enter_pressed_d = (s_d == S_SEL);
    busy_d          = (s_d == S_WAIT);
  end

  // State and output registers
  always_ff @(posedge clk50 or negedge RST) begin
    if (!RST) begin
      p_q             <= P_IDLE;
      s_q             <= S_IDLE;
      x_q             <= RESET_X;
      y_q             <= RESET_Y;
      enter_held_q    <= 1'b0;
      esc_held_q      <= 1'b0;
      cnt_q           <= 24'd0;
      enter_pressed_q <= 1'b0;
      confirm_q       <= 1'b0;
      esc_q           <= 1'b0;
      busy_q          <= 1'b0;
      terr_q          <= 1'b0;
      seg_q           <= 16'h0000;
    end else begin
      p_q             <= p_d;
      s_q             <= s_d;
      x_q             <= x_d;
      y_q             <= y_d;
      enter_held_q    <= enter_held_d;
      esc_held_q      <= esc_held_d;
      cnt_q           <= cnt_d;
      enter_pressed_q <= enter_pressed_d;
      confirm_q       <= confirm_d;
      esc_q           <= esc_d;
      busy_q          <= busy_d;
      terr_q          <= terr_d;
      seg_q           <= seg_d;
    end
  end

  assign bus.cursor          = {y_q, x_q};
  assign bus.enter_pressed   = enter_pressed_q;
  assign bus.confirm_pressed = confirm_q;
  assign bus.esc_pressed     = esc_q;
  assign bus.busy            = busy_q;
  assign bus.timeout_err     = terr_q;
  assign bus.seg_code        = seg_q;

endmodule

// File: tb/tb_kb_cursor_ctrl.sv
// Self-checking bench for kb_cursor_ctrl: directed scenarios plus randomized
// byte streams compared cycle by cycle against a key-event reference model.
module tb_kb_cursor_ctrl;

  localparam int BU_TO = 16;
  localparam int K_UP = 1, K_DOWN = 2, K_LEFT = 3, K_RIGHT = 4, K_ENTER = 5, K_ESC = 6;
  localparam int M_IDLE = 0, M_SEL = 1, M_WAIT = 2;

  logic clk50 = 1'b0;
  logic RST   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  kb_cursor_ctrl_if bus();

  kb_cursor_ctrl #(.RESET_X(3'd0), .RESET_Y(3'd1), .BU_TIMEOUT(24'd16)) dut (
    .clk50(clk50),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 clk50 = ~clk50;

  // reference model state
  int keymap [int];
  int m_x, m_y, m_mode, m_wait, m_seg;
  bit m_e0, m_f0, m_enter_dn, m_esc_dn, m_conf, m_esc, m_terr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 1; m_mode = M_IDLE; m_wait = 0; m_seg = 0;
    m_e0 = 0; m_f0 = 0; m_enter_dn = 0; m_esc_dn = 0;
    m_conf = 0; m_esc = 0; m_terr = 0;
  endtask

  task automatic key_event(input bit ext, input bit brk, input logic [7:0] c, input int mode);
    int idx;
    int k;
    idx = (int'(ext) << 8) | int'(c);
    k = keymap.exists(idx) ? keymap[idx] : 0;
    if (brk) begin
      if (k == K_ENTER) m_enter_dn = 0;
      if (k == K_ESC)   m_esc_dn = 0;
    end else begin
      m_seg = idx;
      if (k == K_ENTER) begin
        if (!m_enter_dn && mode == M_IDLE) m_mode = M_SEL;
        if (!m_enter_dn && mode == M_SEL) begin
          m_mode = M_WAIT; m_conf = 1; m_wait = 0;
        end
        m_enter_dn = 1;
      end else if (k == K_ESC) begin
        if (!m_esc_dn && mode != M_WAIT) begin
          m_esc = 1; m_mode = M_IDLE;
        end
        m_esc_dn = 1;
      end else if (mode != M_WAIT) begin
        if (k == K_UP)    m_y = (m_y < 7) ? m_y + 1 : 7;
        if (k == K_DOWN)  m_y = (m_y > 0) ? m_y - 1 : 0;
        if (k == K_RIGHT) m_x = (m_x < 7) ? m_x + 1 : 7;
        if (k == K_LEFT)  m_x = (m_x > 0) ? m_x - 1 : 0;
      end
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic d);
    int start_mode;
    start_mode = m_mode;
    m_conf = 0; m_esc = 0; m_terr = 0;
    if (v) begin
      if (c == 8'hE0 && !m_e0 && !m_f0) m_e0 = 1;
      else if (c == 8'hF0 && !m_f0)     m_f0 = 1;
      else begin
        key_event(m_e0, m_f0, c, start_mode);
        m_e0 = 0; m_f0 = 0;
      end
    end
    if (start_mode == M_WAIT) begin
      if (d) m_mode = M_IDLE;
      else begin
        m_wait++;
        if (m_wait == BU_TO) begin
          m_terr = 1; m_mode = M_IDLE;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("cursor",  32'(bus.cursor),          32'((m_y << 3) | m_x));
    check_eq("enter",   32'(bus.enter_pressed),   32'(m_mode == M_SEL));
    check_eq("confirm", 32'(bus.confirm_pressed), 32'(m_conf));
    check_eq("esc",     32'(bus.esc_pressed),     32'(m_esc));
    check_eq("busy",    32'(bus.busy),            32'(m_mode == M_WAIT));
    check_eq("timeout", 32'(bus.timeout_err),     32'(m_terr));
    check_eq("seg",     32'(bus.seg_code),        32'(m_seg));
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic d);
    bus.scan_valid = v; bus.scan_code = c; bus.done_bu = d;
    @(posedge clk50);
    model_edge(v, c, d);
    #1;
    compare_all();
    bus.scan_valid = 1'b0; bus.done_bu = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0);
  endtask

  // reset asserted mid-cycle and released on a falling edge
  task automatic apply_reset();
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk50);
    RST = 1'b1;
  endtask

  task automatic enter_confirm();
    send(8'hF0); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A); send(8'h5A);
  endtask

  initial begin
    logic [7:0] pool [13];
    logic [7:0] c;
    int r;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h76, 8'hE0, 8'hF0,
             8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    keymap[9'h01D] = K_UP;    keymap[9'h175] = K_UP;
    keymap[9'h01B] = K_DOWN;  keymap[9'h172] = K_DOWN;
    keymap[9'h01C] = K_LEFT;  keymap[9'h16B] = K_LEFT;
    keymap[9'h023] = K_RIGHT; keymap[9'h174] = K_RIGHT;
    keymap[9'h05A] = K_ENTER; keymap[9'h15A] = K_ENTER;
    keymap[9'h076] = K_ESC;
    bus.scan_valid = 1'b0; bus.scan_code = 8'h00; bus.done_bu = 1'b0;
    model_reset();

    apply_reset();
    check_eq("rst_cursor", 32'(bus.cursor), 32'h08);
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'hE0); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74);
    check_eq("v1_cursor", 32'(bus.cursor), 32'h11);
    check_eq("v1_seg", 32'(bus.seg_code), 32'h0174);

    apply_reset();
    for (int i = 0; i < 8; i++) send(8'h1B);
    for (int i = 0; i < 8; i++) send(8'h1C);
    check_eq("sat_low", 32'(bus.cursor), 32'h00);
    for (int i = 0; i < 9; i++) send(8'h1D);
    for (int i = 0; i < 9; i++) begin send(8'hE0); send(8'h74); end
    check_eq("sat_high", 32'(bus.cursor), 32'h3F);

    apply_reset();
    send(8'h5A);
    check_eq("sel_enter", 32'(bus.enter_pressed), 32'h1);
    send(8'h5A); send(8'hF0); send(8'h5A); send(8'h5A);
    check_eq("confirm_pulse", 32'(bus.confirm_pressed), 32'h1);
    check_eq("confirm_busy", 32'(bus.busy), 32'h1);
    send(8'h1D); send(8'h5A);
    step(1'b0, 8'h00, 1'b1);
    check_eq("wait_cursor", 32'(bus.cursor), 32'h08);
    check_eq("done_busy", 32'(bus.busy), 32'h0);

    enter_confirm();
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0);
    check_eq("pre_timeout", 32'(bus.timeout_err), 32'h0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("timeout_pulse", 32'(bus.timeout_err), 32'h1);
    check_eq("timeout_idle", 32'(bus.busy), 32'h0);
    enter_confirm();
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check_eq("done_wins", 32'(bus.timeout_err), 32'h0);

    apply_reset();
    send(8'h5A); send(8'hF0); send(8'h5A); send(8'h76);
    check_eq("esc_pulse", 32'(bus.esc_pressed), 32'h1);
    check_eq("esc_enter", 32'(bus.enter_pressed), 32'h0);
    send(8'hE0);
    apply_reset();
    send(8'h75);
    check_eq("prefix_lost", 32'(bus.cursor), 32'h08);
    check_eq("prefix_seg", 32'(bus.seg_code), 32'h0075);

    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(99, 0));
      if (r == 0) begin
        apply_reset();
      end else begin
        c = pool[$urandom_range(12, 0)];
        if ($urandom_range(9, 0) == 0) c = 8'($urandom);
        step(1'($urandom_range(1, 0)), c, 1'($urandom_range(19, 0) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
